// File: rtl/sr_latch_sequencer.sv
// Synchronous front-end for a cross-coupled NOR SR latch: synchronizes async set/reset
// requests, arbitrates them and emits clean, mutually exclusive fixed-width S/R pulses.
module sr_latch_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 2,
    parameter int HOLDOFF     = 1,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic             S_ASYNC,
    input  logic             R_ASYNC,
    input  logic             EN,
    output logic             S_OUT,
    output logic             R_OUT,
    output logic             Q_EXP,
    output logic             BUSY,
    output logic             CONFLICT,
    output logic [CNT_W-1:0] CONFLICT_CNT
);

    localparam int TMAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF - 1);

    typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE, HOLD} state_t;

    state_t                 state;
    logic [TW-1:0]          timer;
    logic [SYNC_STAGES-1:0] s_sync;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   s_prev;
    logic                   r_prev;
    logic                   s_edge;
    logic                   r_edge;
    logic                   pend_s;
    logic                   pend_r;
    logic                   last_served_s;
    logic                   start_s;
    logic                   start_r;
    logic                   conflict_now;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            s_sync <= '0;
            r_sync <= '0;
            s_prev <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            s_sync <= {s_sync[SYNC_STAGES-2:0], S_ASYNC};
            r_sync <= {r_sync[SYNC_STAGES-2:0], R_ASYNC};
            s_prev <= s_sync[SYNC_STAGES-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s_edge = s_sync[SYNC_STAGES-1] & ~s_prev;
    assign r_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    // On a tie the input that was not served most recently wins.
    assign conflict_now = (state == IDLE) && pend_s && pend_r;
    assign start_s      = (state == IDLE) && pend_s && (!pend_r || !last_served_s);
    assign start_r      = (state == IDLE) && pend_r && (!pend_s || last_served_s);

    // A new edge in the same cycle as the pulse start re-arms the flag.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            pend_s <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            if (s_edge && EN)
                pend_s <= 1'b1;
            else if (start_s)
                pend_s <= 1'b0;
            if (r_edge && EN)
                pend_r <= 1'b1;
            else if (start_r)
                pend_r <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state         <= IDLE;
            timer         <= '0;
            S_OUT         <= 1'b0;
            R_OUT         <= 1'b0;
            Q_EXP         <= 1'b0;
            BUSY          <= 1'b0;
            CONFLICT      <= 1'b0;
            CONFLICT_CNT  <= '0;
            last_served_s <= 1'b0;
        end else begin
            CONFLICT <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (start_s) begin
                        state <= SET_PULSE;
                        S_OUT <= 1'b1;
                        BUSY  <= 1'b1;
                    end else if (start_r) begin
                        state <= RST_PULSE;
                        R_OUT <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                    if (conflict_now) begin
                        CONFLICT <= 1'b1;
                        if (CONFLICT_CNT != '1)
                            CONFLICT_CNT <= CONFLICT_CNT + CNT_W'(1);
                    end
                end
                SET_PULSE: begin
                    if (timer == PULSE_LAST) begin
                        state         <= HOLD;
                        timer         <= '0;
                        S_OUT         <= 1'b0;
                        Q_EXP         <= 1'b1;
                        last_served_s <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RST_PULSE: begin
                    if (timer == PULSE_LAST) begin
                        state         <= HOLD;
                        timer         <= '0;
                        R_OUT         <= 1'b0;
                        Q_EXP         <= 1'b0;
                        last_served_s <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                HOLD: begin
                    if (timer == HOLD_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    S_OUT <= 1'b0;
                    R_OUT <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Self-checking bench for sr_latch_sequencer: table-driven request vectors with a pulse
// scoreboard, plus hand sequences for latency, EN drop mid-pulse and resets mid-pulse.
module tb_sr_latch_sequencer;

    localparam int PULSE_W = 2;
    localparam int HOLDOFF = 1;

    logic       CLK = 1'b0;
    logic       N_RESET;
    logic       S_ASYNC;
    logic       R_ASYNC;
    logic       EN;
    logic       S_OUT, R_OUT, Q_EXP, BUSY, CONFLICT;
    logic [7:0] CONFLICT_CNT;
    logic       s_out2, r_out2, q_exp2, busy2, conflict2;
    logic [1:0] conflict_cnt2;

    sr_latch_sequencer dut (
        .CLK(CLK), .N_RESET(N_RESET), .S_ASYNC(S_ASYNC), .R_ASYNC(R_ASYNC), .EN(EN),
        .S_OUT(S_OUT), .R_OUT(R_OUT), .Q_EXP(Q_EXP), .BUSY(BUSY),
        .CONFLICT(CONFLICT), .CONFLICT_CNT(CONFLICT_CNT)
    );

    // Narrow counter copy, used only to observe saturation.
    sr_latch_sequencer #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .N_RESET(N_RESET), .S_ASYNC(S_ASYNC), .R_ASYNC(R_ASYNC), .EN(EN),
        .S_OUT(s_out2), .R_OUT(r_out2), .Q_EXP(q_exp2), .BUSY(busy2),
        .CONFLICT(conflict2), .CONFLICT_CNT(conflict_cnt2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit is_set;
        bit conflict;
    } exp_t;

    typedef struct {
        bit s;
        bit r;
        bit en;
        bit first_s;
        int npulses;
        bit exp_q;
        int exp_cnt;
        int exp_cnt2;
    } vec_t;

    exp_t exp_q[$];
    exp_t e_mon;
    vec_t vecs[12];

    int  n_vectors = 0;
    int  n_miscompares = 0;
    bit  mon_on = 0;
    bit  prev_s, prev_r, cur_set;
    int  high_cnt, gap;

    function automatic void check_output(string name, int act, int exp);
        n_vectors++;
        if (act != exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Pulse monitor: pops the scoreboard on every pulse start and checks shape.
    always @(negedge CLK) begin
        if (!mon_on) begin
            prev_s   = 1'b0;
            prev_r   = 1'b0;
            cur_set  = 1'b0;
            high_cnt = 0;
            gap      = 100;
        end else begin
            check_output("s_r_exclusive", int'(S_OUT & R_OUT), 0);
            if ((S_OUT || R_OUT) && !(prev_s || prev_r)) begin
                cur_set  = S_OUT;
                high_cnt = 1;
                check_output("holdoff_gap", int'(gap >= HOLDOFF + 1), 1);
                check_output("busy_in_pulse", int'(BUSY), 1);
                if (exp_q.size() == 0) begin
                    check_output("unexpected_pulse_is_set", int'(S_OUT), -1);
                end else begin
                    e_mon = exp_q.pop_front();
                    check_output("pulse_kind_is_set", int'(S_OUT), int'(e_mon.is_set));
                    check_output("conflict_flag", int'(CONFLICT), int'(e_mon.conflict));
                end
            end else if (S_OUT || R_OUT) begin
                high_cnt++;
            end else if (prev_s || prev_r) begin
                check_output("pulse_width", high_cnt, PULSE_W);
                check_output("q_exp_after_pulse", int'(Q_EXP), int'(cur_set));
                gap = 1;
            end else if (gap < 100) begin
                gap++;
            end
            prev_s = S_OUT;
            prev_r = R_OUT;
        end
    end

    task automatic wait_idle(input int min_cycles);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (i >= min_cycles && exp_q.size() == 0 && !BUSY)
                done = 1;
        end
        check_output("idle_timeout", int'(done), 1);
    endtask

    task automatic wait_for_out(input bit want_s);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            seen = want_s ? S_OUT : R_OUT;
        end
        check_output("pulse_start_timeout", int'(seen), 1);
    endtask

    task automatic apply_stimulus(input vec_t v);
        S_ASYNC = 1'b0;
        R_ASYNC = 1'b0;
        repeat (4) @(negedge CLK);
        EN = v.en;
        if (v.npulses >= 1) exp_q.push_back('{v.first_s, v.npulses == 2});
        if (v.npulses == 2) exp_q.push_back('{!v.first_s, 1'b0});
        S_ASYNC = v.s;
        R_ASYNC = v.r;
        wait_idle(8);
        EN = 1'b1;
    endtask

    task automatic quiet_window(input string name);
        bit any = 0;
        repeat (10) begin
            @(negedge CLK);
            any |= S_OUT | R_OUT | BUSY;
        end
        check_output(name, int'(any), 0);
    endtask

    initial begin
        //          s  r  en fs np q  cnt cnt2
        vecs[0]  = '{1, 0, 1, 1, 1, 1, 0, 0};
        vecs[1]  = '{1, 0, 1, 1, 1, 1, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 1, 2, 0, 1, 1};
        vecs[4]  = '{1, 1, 1, 1, 2, 0, 2, 2};
        vecs[5]  = '{1, 0, 1, 1, 1, 1, 2, 2};
        vecs[6]  = '{1, 1, 1, 0, 2, 1, 3, 3};
        vecs[7]  = '{1, 1, 1, 0, 2, 1, 4, 3};
        vecs[8]  = '{1, 1, 1, 0, 2, 1, 5, 3};
        vecs[9]  = '{0, 1, 0, 0, 0, 1, 5, 3};
        vecs[10] = '{1, 1, 0, 0, 0, 1, 5, 3};
        vecs[11] = '{0, 1, 1, 0, 1, 0, 5, 3};

        N_RESET = 1'b0;
        S_ASYNC = 1'b0;
        R_ASYNC = 1'b0;
        EN      = 1'b1;
        repeat (2) @(negedge CLK);
        N_RESET = 1'b1;
        repeat (10) @(negedge CLK);
        check_output("reset_s_out", int'(S_OUT), 0);
        check_output("reset_r_out", int'(R_OUT), 0);
        check_output("reset_q_exp", int'(Q_EXP), 0);
        check_output("reset_busy", int'(BUSY), 0);
        check_output("reset_conflict", int'(CONFLICT), 0);
        check_output("reset_conflict_cnt", int'(CONFLICT_CNT), 0);

        // Request latency from an idle controller.
        mon_on = 1'b1;
        exp_q.push_back('{1'b1, 1'b0});
        S_ASYNC = 1'b1;
        repeat (3) @(negedge CLK);
        check_output("latency_before_k0_plus_3", int'(S_OUT), 0);
        @(negedge CLK);
        check_output("latency_at_k0_plus_3", int'(S_OUT), 1);
        wait_idle(0);
        check_output("q_exp_after_first_set", int'(Q_EXP), 1);

        // EN dropped mid pulse must not shorten it.
        S_ASYNC = 1'b0;
        repeat (4) @(negedge CLK);
        exp_q.push_back('{1'b1, 1'b0});
        S_ASYNC = 1'b1;
        wait_for_out(1'b1);
        EN = 1'b0;
        wait_idle(4);
        check_output("q_exp_after_en_drop", int'(Q_EXP), 1);
        EN = 1'b1;

        // Sub-cycle reset pulse while S_OUT is high.
        mon_on  = 1'b0;
        S_ASYNC = 1'b0;
        repeat (4) @(negedge CLK);
        S_ASYNC = 1'b1;
        wait_for_out(1'b1);
        #2;
        N_RESET = 1'b0;
        S_ASYNC = 1'b0;
        #1;
        check_output("short_reset_s_out", int'(S_OUT), 0);
        check_output("short_reset_busy", int'(BUSY), 0);
        check_output("short_reset_q_exp", int'(Q_EXP), 0);
        #1;
        N_RESET = 1'b1;
        quiet_window("short_reset_residual_activity");
        check_output("short_reset_cnt", int'(CONFLICT_CNT), 0);

        mon_on = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_q_exp", i), int'(Q_EXP), int'(vecs[i].exp_q));
            check_output($sformatf("vec%0d_conflict_cnt", i), int'(CONFLICT_CNT), vecs[i].exp_cnt);
            check_output($sformatf("vec%0d_sat_cnt", i), int'(conflict_cnt2), vecs[i].exp_cnt2);
        end

        // Reset during the first cycle of an R pulse.
        mon_on  = 1'b0;
        S_ASYNC = 1'b0;
        R_ASYNC = 1'b0;
        repeat (4) @(negedge CLK);
        R_ASYNC = 1'b1;
        wait_for_out(1'b0);
        #1;
        N_RESET = 1'b0;
        R_ASYNC = 1'b0;
        #1;
        check_output("rst_pulse_reset_r_out", int'(R_OUT), 0);
        check_output("rst_pulse_reset_busy", int'(BUSY), 0);
        @(negedge CLK);
        N_RESET = 1'b1;
        quiet_window("rst_pulse_reset_residual_activity");
        check_output("rst_pulse_reset_q_exp", int'(Q_EXP), 0);
        check_output("rst_pulse_reset_cnt", int'(CONFLICT_CNT), 0);

        // A fresh S request must produce exactly one S pulse: no stale pending R.
        mon_on = 1'b1;
        exp_q.push_back('{1'b1, 1'b0});
        S_ASYNC = 1'b1;
        wait_idle(8);
        repeat (6) @(negedge CLK);
        check_output("post_reset_q_exp", int'(Q_EXP), 1);
        check_output("post_reset_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
